// File: rtl/lcb_pkg.sv
// rtl/lcb_pkg.sv - shared frame constants, state encoding and parity helper
package lcb_pkg;

  localparam int DATA_BITS = 16;
  localparam int WORD_BITS = 19;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    GAP    = ST_GAP
  } state_t;

  // Odd parity: data bits plus parity bit always hold an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/rq_frame_tx_if.sv
// rtl/rq_frame_tx_if.sv - request, response-buffer write port and serial status signals
interface rq_frame_tx_if;
  logic        RQ;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        tx;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    output RQ, wr_en, wr_addr, wr_data,
    input  tx, busy, done, overrun
  );

  modport slave (
    input  RQ, wr_en, wr_addr, wr_data,
    output tx, busy, done, overrun
  );
endinterface

// File: rtl/bit_tick_gen.sv
// rtl/bit_tick_gen.sv - one-cycle tick every BIT_DIV clocks, restartable at frame start
module bit_tick_gen #(
  parameter int BIT_DIV = 80
) (
  input  logic clk80MHz,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(BIT_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk80MHz) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/rq_frame_tx.sv
// rtl/rq_frame_tx.sv - on each RQ rising edge, serialises the snapshotted response buffer
// as NWORDS start/16 data/odd parity/stop frames separated by idle gap bits.
module rq_frame_tx
  import lcb_pkg::*;
#(
  parameter int BIT_DIV  = 80,
  parameter int NWORDS   = 4,
  parameter int GAP_BITS = 2
) (
  input logic           clk80MHz,
  input logic           rst,
  rq_frame_tx_if.slave  bus
);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_GAP  = 4'(GAP_BITS - 1);
  localparam logic [2:0] LAST_WORD = 3'(NWORDS - 1);

  state_t      state, state_n;
  logic [3:0]  bit_idx, bit_idx_n;
  logic [2:0]  word_idx, word_idx_n;
  logic        rq_q, rq_armed, edge_det, accept;
  logic        tick, busy_i, tx_i;
  logic        done_q, done_n, overrun_q;
  logic [15:0] rbuf   [8];
  logic [15:0] shadow [8];
  logic [15:0] cur_word;

  assign busy_i   = (state != IDLE);
  // rq_armed blocks a level that was already high across reset from counting as an edge.
  assign edge_det = bus.RQ && !rq_q && rq_armed;
  assign accept   = edge_det && !busy_i;

  bit_tick_gen #(.BIT_DIV(BIT_DIV)) u_tick (
    .clk80MHz (clk80MHz),
    .rst      (rst),
    .restart  (accept),
    .en       (busy_i),
    .tick     (tick)
  );

  always_ff @(posedge clk80MHz) begin
    if (bus.wr_en && (int'(bus.wr_addr) < NWORDS)) begin
      rbuf[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk80MHz) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      word_idx  <= '0;
      rq_q      <= 1'b0;
      rq_armed  <= !bus.RQ;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_idx_n;
      word_idx  <= word_idx_n;
      rq_q      <= bus.RQ;
      rq_armed  <= rq_armed || !bus.RQ;
      done_q    <= done_n;
      overrun_q <= edge_det && busy_i;
      if (accept) begin
        for (int i = 0; i < 8; i++) shadow[i] <= rbuf[i];
      end
    end
  end

  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    word_idx_n = word_idx;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n    = START;
          bit_idx_n  = '0;
          word_idx_n = '0;
        end
      end
      START: begin
        if (tick) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_DATA) state_n = PARITY;
          else                      bit_idx_n = bit_idx + 4'd1;
        end
      end
      PARITY: begin
        if (tick) state_n = STOP;
      end
      STOP: begin
        if (tick) begin
          bit_idx_n = '0;
          if (word_idx == LAST_WORD) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (GAP_BITS > 0) begin
            state_n = GAP;
          end else begin
            state_n    = START;
            word_idx_n = word_idx + 3'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (bit_idx == LAST_GAP) begin
            state_n    = START;
            bit_idx_n  = '0;
            word_idx_n = word_idx + 3'd1;
          end else begin
            bit_idx_n = bit_idx + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cur_word = shadow[word_idx];

  always_comb begin
    tx_i = 1'b1;
    case (state)
      START:   tx_i = 1'b0;
      DATA:    tx_i = cur_word[bit_idx];
      PARITY:  tx_i = odd_parity(cur_word);
      default: tx_i = 1'b1;
    endcase
  end

  assign bus.tx      = tx_i;
  assign bus.busy    = busy_i;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_rq_frame_tx.sv
// tb/tb_rq_frame_tx.sv - directed vector bench for rq_frame_tx (default and small configs)
module tb_rq_frame_tx;
  logic clk = 1'b0;
  logic rst;

  rq_frame_tx_if bus ();
  rq_frame_tx_if sif ();

  rq_frame_tx u_dut (
    .clk80MHz (clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  rq_frame_tx #(.BIT_DIV(4), .NWORDS(1), .GAP_BITS(0)) u_small (
    .clk80MHz (clk),
    .rst      (rst),
    .bus      (sif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] words;
    logic [3:0]  par;
  } vec_t;

  vec_t vecs [3];
  int   tests = 0;
  int   fails = 0;
  logic samples [$];
  int   busy_len, dn_cnt, ov_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic f_busy(input bit s); return s ? sif.busy : bus.busy; endfunction
  function automatic logic f_tx(input bit s); return s ? sif.tx : bus.tx; endfunction
  function automatic logic f_done(input bit s); return s ? sif.done : bus.done; endfunction
  function automatic logic f_ov(input bit s); return s ? sif.overrun : bus.overrun; endfunction

  task automatic set_rq(input bit s, input logic v);
    if (s) sif.RQ = v;
    else   bus.RQ = v;
  endtask

  task automatic write_word(input bit s, input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    if (s) begin sif.wr_en = 1'b1; sif.wr_addr = a; sif.wr_data = d; end
    else   begin bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; end
    @(negedge clk);
    sif.wr_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  function automatic logic samp(input int i);
    if (i >= 0 && i < samples.size()) return samples[i];
    return 1'bx;
  endfunction

  // Pulses RQ, then records tx once per busy cycle; ends on the first idle cycle.
  task automatic run_frame(input bit s, input int ov_at, input bit do_wr,
                           input logic [2:0] wa, input logic [15:0] wd);
    int i;
    samples.delete();
    dn_cnt = 0;
    ov_cnt = 0;
    @(negedge clk);
    set_rq(s, 1'b1);
    if (do_wr) begin bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd; end
    @(negedge clk);
    set_rq(s, 1'b0);
    bus.wr_en = 1'b0;
    i = 0;
    while (f_busy(s) && i < 20000) begin
      samples.push_back(f_tx(s));
      if (f_done(s)) dn_cnt++;
      if (f_ov(s)) ov_cnt++;
      if (i == ov_at) set_rq(s, 1'b1);
      if (i == ov_at + 1) set_rq(s, 1'b0);
      i++;
      @(negedge clk);
    end
    busy_len = i;
    if (f_done(s)) dn_cnt++;
    if (f_ov(s)) ov_cnt++;
  endtask

  task automatic check_frame(input logic [63:0] words, input logic [3:0] par, input int nw,
                             input int bd, input int gap, input int exp_busy, input string tag);
    int base;
    logic [15:0] d;
    for (int w = 0; w < nw; w++) begin
      base = w * (lcb_pkg::WORD_BITS + gap) * bd;
      chk($sformatf("%s w%0d start", tag, w), 32'(samp(base + bd / 2)), 32'd0);
      for (int k = 0; k < 16; k++) d[k] = samp(base + (1 + k) * bd + bd / 2);
      chk($sformatf("%s w%0d data", tag, w), 32'(d), 32'(words[w*16 +: 16]));
      chk($sformatf("%s w%0d parity", tag, w), 32'(samp(base + 17 * bd + bd / 2)), 32'(par[w]));
      chk($sformatf("%s w%0d stop", tag, w), 32'(samp(base + 18 * bd + bd / 2)), 32'd1);
      if (w < nw - 1 && gap > 0)
        chk($sformatf("%s w%0d gap", tag, w), 32'(samp(base + 19 * bd + bd / 2)), 32'd1);
    end
    chk($sformatf("%s busy cycles", tag), 32'(busy_len), 32'(exp_busy));
    chk($sformatf("%s done pulses", tag), 32'(dn_cnt), 32'd1);
  endtask

  initial begin
    int busy_seen, done_seen;
    vecs[0] = '{64'h0000_FFFF_0001_A5C3, 4'b1101};
    vecs[1] = '{64'h00FF_7FFF_8000_1234, 4'b1000};
    vecs[2] = '{64'hFFFE_5555_AAAA_0003, 4'b0111};

    rst = 1'b1;
    bus.RQ = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    sif.RQ = 1'b0; sif.wr_en = 1'b0; sif.wr_addr = '0; sif.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(bus.tx), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset overrun", 32'(bus.overrun), 32'd0);
    chk("reset small busy", 32'(sif.busy), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < 4; a++) write_word(1'b0, 3'(a), vecs[v].words[a*16 +: 16]);
      run_frame(1'b0, -1, 1'b0, 3'd0, 16'h0);
      check_frame(vecs[v].words, vecs[v].par, 4, 80, 2, 6560, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d overrun", v), 32'(ov_cnt), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d idle after", v), 32'(bus.busy), 32'd0);
      chk($sformatf("vec%0d done single", v), 32'(bus.done), 32'd0);
    end

    // Second edge mid-transfer is flagged and ignored.
    run_frame(1'b0, 1000, 1'b0, 3'd0, 16'h0);
    check_frame(vecs[2].words, vecs[2].par, 4, 80, 2, 6560, "ovr");
    chk("ovr pulse cycles", 32'(ov_cnt), 32'd1);
    repeat (3) @(negedge clk);
    chk("ovr no retrigger", 32'(bus.busy), 32'd0);

    // Write colliding with the accepted edge must not reach the frame in flight.
    write_word(1'b0, 3'd0, 16'hBEEF);
    run_frame(1'b0, -1, 1'b1, 3'd0, 16'h1234);
    check_frame(64'hFFFE_5555_AAAA_BEEF, 4'b0110, 4, 80, 2, 6560, "coll1");
    run_frame(1'b0, -1, 1'b0, 3'd0, 16'h0);
    check_frame(64'hFFFE_5555_AAAA_1234, 4'b0110, 4, 80, 2, 6560, "coll2");

    // Reset in the middle of data bit 7 of word 1, RQ held high throughout.
    write_word(1'b0, 3'd1, 16'h5555);
    @(negedge clk);
    bus.RQ = 1'b1;
    @(negedge clk);
    repeat (2360) @(negedge clk);
    chk("abort pre busy", 32'(bus.busy), 32'd1);
    chk("abort pre tx", 32'(bus.tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort tx", 32'(bus.tx), 32'd1);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    busy_seen = 0;
    done_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
      if (bus.done) done_seen++;
    end
    chk("abort held RQ retrigger", 32'(busy_seen), 32'd0);
    chk("abort late done", 32'(done_seen), 32'd0);
    bus.RQ = 1'b0;

    // Small config: no gap, single word, new edge accepted in the done cycle.
    write_word(1'b1, 3'd0, 16'h8001);
    run_frame(1'b1, -1, 1'b0, 3'd0, 16'h0);
    check_frame(64'h0000_0000_0000_8001, 4'b0001, 1, 4, 0, 76, "small");
    chk("small last stop", 32'(samp(75)), 32'd1);
    chk("small done now", 32'(sif.done), 32'd1);
    sif.RQ = 1'b1;
    @(negedge clk);
    sif.RQ = 1'b0;
    chk("small restart busy", 32'(sif.busy), 32'd1);
    chk("small restart overrun", 32'(sif.overrun), 32'd0);
    chk("small restart tx", 32'(sif.tx), 32'd0);
    repeat (76) @(negedge clk);
    chk("small second end busy", 32'(sif.busy), 32'd0);
    chk("small second done", 32'(sif.done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rq_frame_tx.md
RQ_FRAME_TX -- requirements
Module: rq_frame_tx

Interface
REQ-001 The block SHALL have parameter BIT_DIV, default 80, meaning clk80MHz cycles per serial bit (80 = 1 Mbit/s); legal range 4..255.
REQ-002 The block SHALL have parameter NWORDS, default 4, meaning 16-bit words sent per request; legal range 1..8.
REQ-003 The block SHALL have parameter GAP_BITS, default 2, meaning idle-high bit periods between words; legal range 0..7.
REQ-004 clk80MHz  input  1  the single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 RQ  input  1  request pulse from the request former, synchronous to clk80MHz.
REQ-007 wr_en  input  1  response-buffer write strobe.
REQ-008 wr_addr  input  3  response-buffer word address; addresses >= NWORDS are ignored.
REQ-009 wr_data  input  16  response-buffer write data.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy  output  1  high from the first start bit through the end of the last stop bit.
REQ-012 done  output  1  one-cycle pulse after the last stop bit completes.
REQ-013 overrun  output  1  one-cycle pulse when an RQ rising edge is ignored because busy=1.

Function
REQ-014 The block SHALL detect an RQ rising edge by comparing RQ with a registered copy; a level held high SHALL trigger only once.
REQ-015 The block SHALL hold an NWORDS x 16 response buffer, written on any cycle with wr_en=1 and wr_addr<NWORDS, and not cleared by reset.
REQ-016 On an accepted RQ edge (busy=0), the block SHALL copy the whole buffer into a shadow buffer in the same cycle; later writes SHALL NOT affect the frame in flight.
REQ-017 If wr_en and an accepted RQ edge occur in the same cycle, the shadow SHALL capture the old buffer contents.
REQ-018 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP and GAP; each non-IDLE state SHALL last BIT_DIV cycles per bit.
REQ-019 IDLE -> START on an accepted edge; tx SHALL go low one cycle after the cycle in which the edge is detected.
REQ-020 START (1 bit, tx=0) -> DATA (16 bits, LSB first) -> PARITY (1 bit, odd parity over the 16 data bits) -> STOP (1 bit, tx=1).
REQ-021 STOP -> GAP if more words remain and GAP_BITS>0; STOP -> START if more words remain and GAP_BITS=0; STOP -> IDLE after word NWORDS-1.
REQ-022 GAP SHALL hold tx=1 for GAP_BITS bit periods, then -> START with the word index incremented.
REQ-023 Total busy duration SHALL be exactly BIT_DIV*(19*NWORDS + GAP_BITS*(NWORDS-1)) cycles.
REQ-024 done SHALL pulse in the cycle in which the state returns to IDLE; a new RQ edge in that same cycle SHALL be accepted, not flagged as overrun.
REQ-025 The bit-divider counter SHALL be 8 bits, count 0..BIT_DIV-1 and wrap; the bit index SHALL be 4 bits; the word index SHALL be 3 bits.

Reset
REQ-026 While rst=1: state=IDLE, tx=1, busy=0, done=0, overrun=0, all counters=0, the RQ edge register=0, and the shadow buffer=0.
REQ-027 Reset asserted mid-frame SHALL abort the transfer at the next clock edge, with tx high on that edge and no done pulse.
REQ-028 An RQ held high while reset is released SHALL NOT trigger a transfer until RQ falls and rises again.

Structure
REQ-029 State encoding localparams, frame bit counts (16 data bits, 19 bits per word) and the parity function SHALL live in a shared package, lcb_pkg.
REQ-030 The bit-period divider SHALL be a sub-module, bit_tick_gen, producing a one-cycle tick every BIT_DIV cycles and restarted on frame start.

Verification
REQ-031 Default parameters: write 0xA5C3, 0x0001, 0xFFFF, 0x0000; pulse RQ -> 4 frames, LSB first, with parity bits 1, 0, 1, 1; busy lasts 6560 cycles; one done pulse.
REQ-032 Second RQ edge 1000 cycles into a transfer -> overrun pulse of exactly 1 cycle; the frame is unchanged; no second transfer.
REQ-033 Write word0=0x1234 in the same cycle as the RQ edge, where the old value was 0xBEEF -> transmitted word0 = 0xBEEF; the next request sends 0x1234.
REQ-034 rst asserted during DATA bit 7 of word 1 -> tx=1 and busy=0 on the next edge; no done; RQ held high afterwards does not retrigger.
REQ-035 BIT_DIV=4, GAP_BITS=0, NWORDS=1 -> 76-cycle busy window; stop bit followed directly by IDLE; RQ edge in the done cycle starts a new frame.
